// File: rtl/rr_mux_arb.sv
// ----------------------------------------------------------------------------
// rr_mux_arb -- N-channel arbitrating multiplexer with a one-word output stage.
//
// Selects one of NCH input channels each cycle (fixed priority or round robin,
// chosen per cycle by 'mode'), and registers the winner's data and index into
// a single output word. One word per cycle sustained when out_ready stays high.
//
// Parameters
//   WIDTH : bits per data channel (1..64)
//   NCH   : number of input channels (2..16)
//   CW    : width of a channel index, clog2(NCH)
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous, active-high reset
//   mode       : 0 = fixed priority (lowest index wins), 1 = round robin
//   in_data    : channel i data at [i*WIDTH +: WIDTH]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready (combinational, one-hot or zero)
//   out_data   : registered output data
//   out_ch     : registered index of the channel that sourced out_data
//   out_valid  : registered output valid
//   out_ready  : downstream ready
//   grant_cnt  : (only with RR_MUX_CNT_EN) 16-bit wrapping per-channel
//                accepted-word counters, channel i at [i*16 +: 16]
//
// Optional feature macro: RR_MUX_CNT_EN adds the grant_cnt port and counters.
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. Valid never depends on ready on the same side;
// in_ready depends on in_valid (grant) and on out_valid/out_ready (load).
// A source may drop in_valid without a transfer; the grant simply moves.
// ----------------------------------------------------------------------------
module rr_mux_arb #(
    parameter int WIDTH = 3,
    parameter int NCH   = 4,
    localparam int CW   = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CW-1:0]        out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef RR_MUX_CNT_EN
    ,
    output logic [NCH*16-1:0]    grant_cnt
`endif
);

    // Last accepted channel; reset value NCH-1 makes channel 0 first in RR.
    logic [CW-1:0]      ptr;
    logic               load;
    logic [2*NCH-1:0]   valid2;
    logic [NCH-1:0]     rot;
    logic [NCH-1:0]     cand;
    int                 rr_base;
    int                 pe;
    logic               grant_any;
    logic [CW-1:0]      grant_idx;
    logic               take;

    // The output register can accept a new word when empty or draining.
    assign load = !out_valid || out_ready;

    // Round robin is done by rotating the valid vector so that channel
    // ptr+1 lands at bit 0, priority-encoding, then adding the offset back.
    always_comb begin
        rr_base   = (int'(ptr) + 1) % NCH;
        valid2    = {in_valid, in_valid};
        rot       = NCH'(valid2 >> rr_base);
        cand      = mode ? rot : in_valid;
        pe        = 0;
        grant_any = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                pe        = i;
                grant_any = 1'b1;
            end
        end
        grant_idx = mode ? CW'((pe + rr_base) % NCH) : CW'(pe);
    end

    always_comb begin
        in_ready = '0;
        if (!rst && load && grant_any) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign take = |(in_valid & in_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= CW'(NCH - 1);
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
            out_ch    <= grant_idx;
            ptr       <= grant_idx;
        end else if (load) begin
            // Nothing to take: drop valid, keep the last word for debug.
            out_valid <= 1'b0;
        end
    end

`ifdef RR_MUX_CNT_EN
    logic [15:0] cnt_q [NCH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (take) begin
            cnt_q[grant_idx] <= cnt_q[grant_idx] + 16'd1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_cnt
        assign grant_cnt[g*16 +: 16] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_rr_mux_arb.sv
// ----------------------------------------------------------------------------
// tb_rr_mux_arb -- self-checking bench for rr_mux_arb (WIDTH=3, NCH=4).
// A behavioural model predicts outputs from the arbitration rules; a negedge
// compare process checks every cycle; directed sequences pin literal values.
// With RR_MUX_CNT_EN defined the grant counters are also checked.
// ----------------------------------------------------------------------------
module tb_rr_mux_arb;
    localparam int W  = 3;
    localparam int N  = 4;
    localparam int CW = $clog2(N);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             mode;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [W-1:0]     out_data;
    logic [CW-1:0]    out_ch;
    logic             out_valid;
    logic             out_ready;
`ifdef RR_MUX_CNT_EN
    logic [N*16-1:0]  grant_cnt;
`endif

    rr_mux_arb #(.WIDTH(W), .NCH(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef RR_MUX_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Search order: fixed = 0,1,..,N-1; round robin = p+1, p+2, ... mod N.
    function automatic int exp_grant(input logic [N-1:0] v, input logic md, input int p);
        for (int k = 0; k < N; k++) begin
            int c;
            c = md ? (p + 1 + k) % N : k;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    bit           model_init = 1'b0;
    logic         m_ov;
    logic [W-1:0] m_od;
    int           m_och;
    int           m_ptr;
    logic [15:0]  m_cnt [N];
    int           m_g;
    logic [N-1:0] e_ready;

    always_comb begin
        m_g     = exp_grant(in_valid, mode, m_ptr);
        e_ready = '0;
        if (!rst && (!m_ov || out_ready) && m_g >= 0) e_ready[m_g] = 1'b1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ov       <= 1'b0;
            m_od       <= '0;
            m_och      <= 0;
            m_ptr      <= N - 1;
            for (int c = 0; c < N; c++) m_cnt[c] <= '0;
            model_init <= 1'b1;
        end else if (!m_ov || out_ready) begin
            if (m_g >= 0) begin
                m_ov       <= 1'b1;
                m_od       <= in_data[m_g*W +: W];
                m_och      <= m_g;
                m_ptr      <= m_g;
                m_cnt[m_g] <= m_cnt[m_g] + 16'd1;
            end else begin
                m_ov <= 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (model_init) begin
            chk("out_valid", 64'(out_valid), 64'(m_ov));
            chk("out_data",  64'(out_data),  64'(m_od));
            chk("out_ch",    64'(out_ch),    64'(m_och));
            chk("in_ready",  64'(in_ready),  64'(e_ready));
`ifdef RR_MUX_CNT_EN
            for (int c = 0; c < N; c++) begin
                chk("grant_cnt", 64'(grant_cnt[c*16 +: 16]), 64'(m_cnt[c]));
            end
`endif
        end
    end

    // ---------------- driver ----------------
    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic step_check();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 1'b1;
        in_valid  = '1;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset with every channel requesting.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_out_ch",    64'(out_ch),    64'd0);

        // Round robin, all valid: 0,1,2,3,0,1,2,3 one per cycle.
        next_drive();
        rst      = 1'b0;
        mode     = 1'b1;
        in_valid = 4'hF;
        in_data  = {3'd4, 3'd3, 3'd2, 3'd1};
        for (int i = 0; i < 8; i++) begin
            step_check();
            chk("rr_seq_ch",    64'(out_ch),    64'(i % 4));
            chk("rr_seq_valid", 64'(out_valid), 64'd1);
            chk("rr_seq_data",  64'(out_data),  64'(i % 4 + 1));
        end

        // Fixed priority: channels 1 and 3, channel 1 always wins.
        next_drive();
        mode     = 1'b0;
        in_valid = 4'b1010;
        in_data  = {3'h2, 3'h0, 3'h5, 3'h0};
        for (int i = 0; i < 4; i++) begin
            step_check();
            chk("fp_ch",   64'(out_ch),   64'd1);
            chk("fp_data", 64'(out_data), 64'h5);
        end

        // Backpressure for 5 cycles: word held, nothing accepted.
        next_drive();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step_check();
            chk("bp_data",     64'(out_data),  64'h5);
            chk("bp_ch",       64'(out_ch),    64'd1);
            chk("bp_valid",    64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready),  64'd0);
        end

        // Release with only channel 2 valid: ptr=1 -> ch2, then ch2 again
        // after wrap with no idle cycle.
        next_drive();
        out_ready = 1'b1;
        mode      = 1'b1;
        in_valid  = 4'b0100;
        in_data   = {3'd0, 3'd6, 3'd0, 3'd0};
        @(negedge clk);
        chk("rel_in_ready", 64'(in_ready), 64'b0100);
        for (int i = 0; i < 3; i++) begin
            step_check();
            chk("sp_ch",    64'(out_ch),    64'd2);
            chk("sp_valid", 64'(out_valid), 64'd1);
            chk("sp_data",  64'(out_data),  64'd6);
        end

        // Randomized traffic with occasional mid-transfer resets.
        for (int i = 0; i < 3000; i++) begin
            next_drive();
            rst       = ($urandom_range(0, 199) == 0);
            mode      = 1'($urandom_range(0, 1));
            in_valid  = N'($urandom);
            in_data   = (N*W)'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
        end
        next_drive();
        rst = 1'b0;

`ifdef RR_MUX_CNT_EN
        // 70000 back-to-back words on channel 0: counter wraps to 4464.
        next_drive();
        rst = 1'b1;
        next_drive();
        rst       = 1'b0;
        mode      = 1'b0;
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        in_valid = '0;
        @(negedge clk);
        chk("cnt_wrap", 64'(grant_cnt[15:0]), 64'd4464);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux_arb.md
RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 Parameter WIDTH, default 3, bit width of each data channel; the block SHALL support WIDTH 1..64.
REQ-002 Parameter NCH, default 4, number of input channels; the block SHALL support NCH 2..16.
REQ-003 The block SHALL derive localparam CW = clog2(NCH), the width of the channel index.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 mode  input  1  arbitration mode: 0 = fixed priority, 1 = round robin.
REQ-007 in_data  input  NCH*WIDTH  channel i data SHALL occupy bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  NCH  per-channel valid.
REQ-009 in_ready  output  NCH  per-channel ready, combinational.
REQ-010 out_data  output  WIDTH  registered output data.
REQ-011 out_ch  output  CW  registered index of the channel that sourced out_data.
REQ-012 out_valid  output  1  registered output valid.
REQ-013 out_ready  input  1  downstream ready.

Function
REQ-014 Transfer rules:
- An input transfer SHALL occur on channel i when in_valid[i] && in_ready[i].
- An output transfer SHALL occur when out_valid && out_ready.
REQ-015 The block SHALL define load = !out_valid || out_ready.
REQ-016 When load=1, the block SHALL assert in_ready only on the granted channel; all other in_ready bits SHALL be 0.
REQ-017 When load=0, all in_ready bits SHALL be 0.
REQ-018 Fixed mode (mode=0): the grant SHALL go to the lowest-index channel with in_valid=1.
REQ-019 Round-robin mode (mode=1): the grant SHALL go to the first valid channel searching upward from ptr+1 modulo NCH, where ptr is the last accepted channel.
REQ-020 On an input transfer, the block SHALL capture the following on the next edge, giving 1-cycle latency:
- out_data = granted channel's data
- out_ch = granted index
- out_valid = 1
REQ-021 On load=1 with no valid input, out_valid SHALL go to 0 on the next edge; out_data and out_ch SHALL hold.
REQ-022 Backpressure: while out_valid=1 and out_ready=0, out_data, out_ch and out_valid SHALL remain stable.
REQ-023 ptr SHALL update to the granted index only on an input transfer, in both modes; wrap-around SHALL go from NCH-1 to 0.
REQ-024 Full throughput: with out_ready held at 1, one word SHALL be accepted every cycle, including a simultaneous output and input transfer in the same cycle.
REQ-025 The block SHALL sample mode each cycle; a change SHALL affect only the arbitration decision of that cycle, with no flush.
REQ-026 A channel deasserting in_valid without a transfer SHALL be legal; the grant SHALL be recomputed combinationally.

Reset
REQ-027 While rst=1, the block SHALL force out_valid=0, out_data=0, out_ch=0 and ptr=NCH-1, so the first round-robin grant goes to channel 0.
REQ-028 While rst=1, all in_ready bits SHALL be 0.
REQ-029 On rst asserted mid-transfer, the held word SHALL be discarded and no input transfer SHALL be counted in that cycle.

Configuration
REQ-030 The block SHALL provide macro RR_MUX_CNT_EN.
REQ-031 When RR_MUX_CNT_EN is defined:
- The block SHALL add output grant_cnt [NCH*16], a 16-bit per-channel counter in slice i*16 +: 16.
- Each counter SHALL increment on every input transfer of its channel and wrap at 0xFFFF to 0.
- rst SHALL clear the counters.
REQ-032 When RR_MUX_CNT_EN is undefined, the grant_cnt port and its logic SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-033 Reset: assert rst with all in_valid=1 -> out_valid=0, in_ready=0; release with mode=1 -> first out_ch=0.
REQ-034 Round robin: NCH=4, all valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3, one word per cycle.
REQ-035 Fixed priority: mode=0, channels 1 and 3 valid with data 3'h5 and 3'h2 -> out_ch stays 1 and out_data 3'h5 while channel 1 remains valid.
REQ-036 Backpressure: out_ready=0 for 5 cycles with a word held -> out_data and out_ch stable, in_ready=0; release -> next grant on the following edge.
REQ-037 Sparse round robin: only channel 2 valid, ptr=2 -> channel 2 granted again after wrap, no idle cycle.
REQ-038 With RR_MUX_CNT_EN: 70000 transfers on channel 0 -> grant_cnt slice 0 = 70000 mod 65536 = 4464.
